// File: rtl/des_pkg.sv
// Shared DES key-schedule constants, permutation tables, state type and rotate helpers.
package des_pkg;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned SUBKEY_W = 48;

  typedef logic [0:HALF_W-1] half_t;

  typedef enum logic [0:0] {StIdle, StRound} state_e;

  // Rotation amount per round; element k holds the amount for round k+1.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // 1-based DES bit numbers, MSB-first.
  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic half_t rotl(input half_t x, input logic [1:0] amt);
    return (amt == 2'd2) ? {x[2:HALF_W-1], x[0:1]} : {x[1:HALF_W-1], x[0]};
  endfunction

  function automatic half_t rotr(input half_t x, input logic [1:0] amt);
    return (amt == 2'd2) ? {x[HALF_W-2:HALF_W-1], x[0:HALF_W-3]}
                         : {x[HALF_W-1], x[0:HALF_W-2]};
  endfunction

endpackage

// File: rtl/des_key_permutation1.sv
// DES PC-1: selects the 56 key bits into the C||D halves, dropping parity bits.
module des_key_permutation1
  import des_pkg::*;
(
  input  logic [0:KEY_W-1]    key_i,
  output logic [0:2*HALF_W-1] cd_o
);

  for (genvar i = 0; i < 2 * HALF_W; i++) begin : g_bit
    assign cd_o[i] = key_i[PC1_TBL[i]-1];
  end

  logic unused_parity;
  assign unused_parity = ^{key_i[7], key_i[15], key_i[23], key_i[31],
                           key_i[39], key_i[47], key_i[55], key_i[63]};

endmodule

// File: rtl/des_key_permutation2.sv
// DES PC-2: compresses the 56-bit C||D state into a 48-bit round subkey.
module des_key_permutation2
  import des_pkg::*;
(
  input  logic [0:2*HALF_W-1] cd_i,
  output logic [0:SUBKEY_W-1] subkey_o
);

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_bit
    assign subkey_o[i] = cd_i[PC2_TBL[i]-1];
  end

  logic unused_cd;
  assign unused_cd = ^{cd_i[8], cd_i[17], cd_i[21], cd_i[24],
                       cd_i[34], cd_i[37], cd_i[42], cd_i[53]};

endmodule

// File: rtl/des_key_scheduler.sv
// Sequential DES key schedule: loads a key and emits the 16 subkeys over valid/ready,
// in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_scheduler
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [0:KEY_W-1]    key_in,
  input  logic                decrypt,
  input  logic                start,
  input  logic                abort,
  output logic [0:SUBKEY_W-1] subkey,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [3:0]          round_idx,
  output logic                busy,
  output logic                done
);

  localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS - 1);

  state_e              state_q;
  half_t               c_q, d_q;
  logic                dec_q;
  logic [3:0]          idx_q;
  logic                done_q;
  logic [0:2*HALF_W-1] cd_pc1;
  half_t               c_load, d_load;

  des_key_permutation1 u_pc1 (
    .key_i (key_in),
    .cd_o  (cd_pc1)
  );

  des_key_permutation2 u_pc2 (
    .cd_i     ({c_q, d_q}),
    .subkey_o (subkey)
  );

  assign c_load = cd_pc1[0:HALF_W-1];
  assign d_load = cd_pc1[HALF_W:2*HALF_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      dec_q   <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_q <= StRound;
            dec_q   <= decrypt;
            idx_q   <= '0;
            // Decrypt starts at C16/D16, which equals C0/D0 after the full 28-bit rotation.
            if (decrypt) begin
              c_q <= c_load;
              d_q <= d_load;
            end else begin
              c_q <= rotl(c_load, SHIFT[0]);
              d_q <= rotl(d_load, SHIFT[0]);
            end
          end
        end
        StRound: begin
          if (abort) begin
            state_q <= StIdle;
            idx_q   <= '0;
          end else if (subkey_ready) begin
            if (idx_q == LastIdx) begin
              state_q <= StIdle;
              idx_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 4'd1;
              // Encrypt steps forward to round idx+2; decrypt steps back undoing round 16-idx.
              if (dec_q) begin
                c_q <= rotr(c_q, SHIFT[LastIdx - idx_q]);
                d_q <= rotr(d_q, SHIFT[LastIdx - idx_q]);
              end else begin
                c_q <= rotl(c_q, SHIFT[idx_q + 4'd1]);
                d_q <= rotl(d_q, SHIFT[idx_q + 4'd1]);
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign subkey_valid = (state_q == StRound);
  assign busy         = (state_q == StRound);
  assign round_idx    = idx_q;
  assign done         = done_q;

endmodule
